// File: rtl/mem_arbiter_pkg.sv
// Shared ISA-level types: word width, memory commands and the arbiter's state/owner encodings.
package instruction_set;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } MEM_OPS_T;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } ARB_STATE_T;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } ARB_OWNER_T;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive core grants taken while the debug port was waiting.
module starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 4'(LIMIT))) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == 4'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single data-memory port: core has priority, debug is
// guaranteed service by the starvation counter. One access in flight at a time.
module mem_arbiter
  import instruction_set::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 core_req,
  input  MEM_OPS_T             core_op,
  input  logic [WORD_SIZE-1:0] core_addr,
  input  logic [WORD_SIZE-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_done,
  output logic [WORD_SIZE-1:0] core_rdata,
  input  logic                 dbg_req,
  input  MEM_OPS_T             dbg_op,
  input  logic [WORD_SIZE-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0] dbg_wdata,
  output logic                 dbg_gnt,
  output logic                 dbg_done,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output MEM_OPS_T             mem_op,
  output logic [WORD_SIZE-1:0] mem_rw_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  ARB_STATE_T state;
  ARB_OWNER_T owner;
  MEM_OPS_T   op_q;
  logic [3:0] lat_cnt;
  logic       idle;
  logic       dbg_win;
  logic       at_limit;

  assign idle    = (state == IDLE);
  assign dbg_win = dbg_req && (!core_req || at_limit);

  // Counter only moves in IDLE, where the arbitration decision is actually made.
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (idle && (!dbg_req || dbg_win)),
    .inc     (idle && dbg_req && !dbg_win),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWN_CORE;
      op_q        <= MEM_NOP;
      lat_cnt     <= '0;
      mem_op      <= MEM_NOP;
      mem_rw_addr <= '0;
      mem_wdata   <= '0;
      core_rdata  <= '0;
      dbg_rdata   <= '0;
      core_gnt    <= 1'b0;
      dbg_gnt     <= 1'b0;
      core_done   <= 1'b0;
      dbg_done    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      core_gnt  <= 1'b0;
      dbg_gnt   <= 1'b0;
      core_done <= 1'b0;
      dbg_done  <= 1'b0;
      mem_op    <= MEM_NOP;
      case (state)
        IDLE: begin
          if (core_req || dbg_req) begin
            state <= ISSUE;
            busy  <= 1'b1;
            if (dbg_win) begin
              owner       <= OWN_DBG;
              op_q        <= dbg_op;
              mem_op      <= dbg_op;
              mem_rw_addr <= dbg_addr;
              mem_wdata   <= dbg_wdata;
              dbg_gnt     <= 1'b1;
            end else begin
              owner       <= OWN_CORE;
              op_q        <= core_op;
              mem_op      <= core_op;
              mem_rw_addr <= core_addr;
              mem_wdata   <= core_wdata;
              core_gnt    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= 4'(MEM_LATENCY - 1);
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state <= RESP;
            if (owner == OWN_DBG) begin
              dbg_done <= 1'b1;
              if (op_q == MEM_READ) dbg_rdata <= mem_rdata;
            end else begin
              core_done <= 1'b1;
              if (op_q == MEM_READ) core_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          busy        <= 1'b0;
          mem_rw_addr <= '0;
          mem_wdata   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (latency 1 and 3) share stimulus tasks; a monitor pops expected events.
module tb_mem_arbiter;
  import instruction_set::*;

  localparam int K_CGNT  = 0;
  localparam int K_DGNT  = 1;
  localparam int K_MEMOP = 2;
  localparam int K_CDONE = 3;
  localparam int K_DDONE = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
    logic [31:0] addr;
    logic [31:0] wd;
  } ev_t;

  logic                 clk;
  logic                 reset_n;
  logic                 core_req   [2];
  MEM_OPS_T             core_op    [2];
  logic [WORD_SIZE-1:0] core_addr  [2];
  logic [WORD_SIZE-1:0] core_wdata [2];
  logic                 core_gnt   [2];
  logic                 core_done  [2];
  logic [WORD_SIZE-1:0] core_rdata [2];
  logic                 dbg_req    [2];
  MEM_OPS_T             dbg_op     [2];
  logic [WORD_SIZE-1:0] dbg_addr   [2];
  logic [WORD_SIZE-1:0] dbg_wdata  [2];
  logic                 dbg_gnt    [2];
  logic                 dbg_done   [2];
  logic [WORD_SIZE-1:0] dbg_rdata  [2];
  MEM_OPS_T             mem_op     [2];
  logic [WORD_SIZE-1:0] mem_rw_addr[2];
  logic [WORD_SIZE-1:0] mem_wdata  [2];
  logic [WORD_SIZE-1:0] mem_rdata  [2];
  logic                 busy       [2];

  int          cyc = 0;
  int          rd_due [2] = '{-1, -1};
  logic [31:0] rd_data[2] = '{32'h0, 32'h0};
  logic        wr_v   [2] = '{1'b0, 1'b0};
  logic [31:0] wr_a   [2] = '{32'h0, 32'h0};
  logic [31:0] wr_d   [2] = '{32'h0, 32'h0};

  ev_t exp_q [2][$];
  int  n_cmp;
  int  n_bad;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 3), .STARVE_LIMIT(4)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .core_req   (core_req[g]),
      .core_op    (core_op[g]),
      .core_addr  (core_addr[g]),
      .core_wdata (core_wdata[g]),
      .core_gnt   (core_gnt[g]),
      .core_done  (core_done[g]),
      .core_rdata (core_rdata[g]),
      .dbg_req    (dbg_req[g]),
      .dbg_op     (dbg_op[g]),
      .dbg_addr   (dbg_addr[g]),
      .dbg_wdata  (dbg_wdata[g]),
      .dbg_gnt    (dbg_gnt[g]),
      .dbg_done   (dbg_done[g]),
      .dbg_rdata  (dbg_rdata[g]),
      .mem_op     (mem_op[g]),
      .mem_rw_addr(mem_rw_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(logic [31:0] a);
    case (a)
      32'h10:  return 32'h5A;
      32'h40:  return 32'h11;
      32'h44:  return 32'h22;
      32'h08:  return 32'hC3;
      default: return {24'hA5A5A5, a[7:0]};
    endcase
  endfunction

  // Memory model: read data is valid only in the cycle issue+latency, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (mem_op[i] == MEM_READ) begin
        rd_due[i]  <= cyc + ((i == 0) ? 1 : 3);
        rd_data[i] <= (wr_v[i] && wr_a[i] == mem_rw_addr[i]) ? wr_d[i] : dflt(mem_rw_addr[i]);
      end
      if (mem_op[i] == MEM_WRITE) begin
        wr_v[i] <= 1'b1;
        wr_a[i] <= mem_rw_addr[i];
        wr_d[i] <= mem_wdata[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = (cyc == rd_due[i]) ? rd_data[i] : 32'hDEAD_BEEF;
    end
  end

  function automatic void push(int i, int k, int c, logic [31:0] v, logic [31:0] a, logic [31:0] w);
    ev_t e;
    e = '{k, c, v, a, w};
    exp_q[i].push_back(e);
  endfunction

  task automatic observe(int i, int k, logic [31:0] v, logic [31:0] a, logic [31:0] w);
    ev_t e;
    n_cmp++;
    if (exp_q[i].size() == 0) begin
      n_bad++;
      $display("FAIL inst%0d unexpected_event: got kind=%0d cyc=%0d val=%h, required none", i, k, cyc, v);
    end else begin
      e = exp_q[i].pop_front();
      if (e.kind != k || e.cyc != cyc || e.val !== v || e.addr !== a || e.wd !== w) begin
        n_bad++;
        $display("FAIL inst%0d event: got kind=%0d cyc=%0d val=%h addr=%h wd=%h, required kind=%0d cyc=%0d val=%h addr=%h wd=%h",
                 i, k, cyc, v, a, w, e.kind, e.cyc, e.val, e.addr, e.wd);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_cycle();
    for (int i = 0; i < 2; i++) begin
      if (core_gnt[i]) observe(i, K_CGNT, 32'h0, 32'h0, 32'h0);
      if (dbg_gnt[i]) observe(i, K_DGNT, 32'h0, 32'h0, 32'h0);
      if (mem_op[i] != MEM_NOP) observe(i, K_MEMOP, 32'(mem_op[i]), mem_rw_addr[i], mem_wdata[i]);
      if (core_done[i]) observe(i, K_CDONE, core_rdata[i], 32'h0, 32'h0);
      if (dbg_done[i]) observe(i, K_DDONE, dbg_rdata[i], 32'h0, 32'h0);
    end
  endtask

  initial begin
    int c0;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      core_req[i] = 1'b0; core_op[i] = MEM_NOP; core_addr[i] = '0; core_wdata[i] = '0;
      dbg_req[i]  = 1'b0; dbg_op[i]  = MEM_NOP; dbg_addr[i]  = '0; dbg_wdata[i]  = '0;
    end
    fork
      forever begin
        @(negedge clk);
        mon_cycle();
      end
    join_none

    step(2);
    for (int i = 0; i < 2; i++) begin
      chk("reset_mem_op", 32'(mem_op[i]), 32'(MEM_NOP));
      chk("reset_addr_wdata", mem_rw_addr[i] | mem_wdata[i], 32'h0);
      chk("reset_rdata", core_rdata[i] | dbg_rdata[i], 32'h0);
      chk("reset_flags", {26'h0, core_gnt[i], core_done[i], dbg_gnt[i], dbg_done[i], busy[i], 1'b0}, 32'h0);
    end
    reset_n = 1'b1;
    step(1);

    // Core read, latency 1.
    c0 = cyc;
    core_req[0] = 1'b1; core_op[0] = MEM_READ; core_addr[0] = 32'h10;
    push(0, K_CGNT, c0 + 1, 0, 0, 0);
    push(0, K_MEMOP, c0 + 1, 32'(MEM_READ), 32'h10, 0);
    push(0, K_CDONE, c0 + 3, 32'h5A, 0, 0);
    step(1);
    core_req[0] = 1'b0;
    chk("busy_issue", 32'(busy[0]), 32'h1);
    step(3);
    chk("busy_idle", 32'(busy[0]), 32'h0);

    // Simultaneous requests: core first, debug after one access period.
    c0 = cyc;
    core_req[0] = 1'b1; core_op[0] = MEM_READ; core_addr[0] = 32'h40;
    dbg_req[0]  = 1'b1; dbg_op[0]  = MEM_READ; dbg_addr[0]  = 32'h44;
    push(0, K_CGNT, c0 + 1, 0, 0, 0);
    push(0, K_MEMOP, c0 + 1, 32'(MEM_READ), 32'h40, 0);
    push(0, K_CDONE, c0 + 3, 32'h11, 0, 0);
    push(0, K_DGNT, c0 + 5, 0, 0, 0);
    push(0, K_MEMOP, c0 + 5, 32'(MEM_READ), 32'h44, 0);
    push(0, K_DDONE, c0 + 7, 32'h22, 0, 0);
    step(1);
    core_req[0] = 1'b0;
    step(4);
    dbg_req[0] = 1'b0;
    step(3);

    // Starvation: four core grants, one debug grant, then core again.
    c0 = cyc;
    core_req[0] = 1'b1; dbg_req[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(0, (k == 4) ? K_DGNT : K_CGNT, c0 + 4 * k + 1, 0, 0, 0);
      push(0, K_MEMOP, c0 + 4 * k + 1, 32'(MEM_READ), (k == 4) ? 32'h44 : 32'h40, 0);
      push(0, (k == 4) ? K_DDONE : K_CDONE, c0 + 4 * k + 3, (k == 4) ? 32'h22 : 32'h11, 0, 0);
    end
    step(17);
    dbg_req[0] = 1'b0;
    step(4);
    core_req[0] = 1'b0;
    step(4);

    // Debug write then read of the same address; rdata untouched by the write.
    c0 = cyc;
    dbg_req[0] = 1'b1; dbg_op[0] = MEM_WRITE; dbg_addr[0] = 32'h20; dbg_wdata[0] = 32'h33;
    push(0, K_DGNT, c0 + 1, 0, 0, 0);
    push(0, K_MEMOP, c0 + 1, 32'(MEM_WRITE), 32'h20, 32'h33);
    push(0, K_DDONE, c0 + 3, 32'h22, 0, 0);
    push(0, K_DGNT, c0 + 5, 0, 0, 0);
    push(0, K_MEMOP, c0 + 5, 32'(MEM_READ), 32'h20, 0);
    push(0, K_DDONE, c0 + 7, 32'h33, 0, 0);
    step(1);
    dbg_op[0] = MEM_READ; dbg_wdata[0] = '0;
    step(4);
    dbg_req[0] = 1'b0;
    step(1);
    chk("dbg_rdata_held", dbg_rdata[0], 32'h22);
    step(2);

    // Reset during WAIT abandons the access; next request proceeds normally.
    c0 = cyc;
    core_req[0] = 1'b1; core_op[0] = MEM_READ; core_addr[0] = 32'h10;
    push(0, K_CGNT, c0 + 1, 0, 0, 0);
    push(0, K_MEMOP, c0 + 1, 32'(MEM_READ), 32'h10, 0);
    step(1);
    core_req[0] = 1'b0;
    step(1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_op", 32'(mem_op[0]), 32'(MEM_NOP));
    chk("rst_mid_busy", 32'(busy[0]), 32'h0);
    chk("rst_mid_rdata", core_rdata[0], 32'h0);
    step(2);
    reset_n = 1'b1;
    step(2);
    c0 = cyc;
    core_req[0] = 1'b1; core_addr[0] = 32'h40;
    push(0, K_CGNT, c0 + 1, 0, 0, 0);
    push(0, K_MEMOP, c0 + 1, 32'(MEM_READ), 32'h40, 0);
    push(0, K_CDONE, c0 + 3, 32'h11, 0, 0);
    step(1);
    core_req[0] = 1'b0;
    step(4);

    // Latency 3 instance: read, then a NOP that never drives the memory.
    c0 = cyc;
    core_req[1] = 1'b1; core_op[1] = MEM_READ; core_addr[1] = 32'h08;
    push(1, K_CGNT, c0 + 1, 0, 0, 0);
    push(1, K_MEMOP, c0 + 1, 32'(MEM_READ), 32'h08, 0);
    push(1, K_CDONE, c0 + 5, 32'hC3, 0, 0);
    step(1);
    core_req[1] = 1'b0;
    step(6);
    c0 = cyc;
    dbg_req[1] = 1'b1; dbg_op[1] = MEM_NOP; dbg_addr[1] = 32'h30; dbg_wdata[1] = 32'h77;
    push(1, K_DGNT, c0 + 1, 0, 0, 0);
    push(1, K_DDONE, c0 + 5, 32'h0, 0, 0);
    step(1);
    dbg_req[1] = 1'b0;
    step(6);

    for (int i = 0; i < 2; i++) begin
      chk("events_outstanding", exp_q[i].size(), 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
